// File: rtl/stream_tx_pkt.sv
// Purpose: sends one packet of pkt_len beats from a first-word-fall-through FIFO onto an AXI-Stream master port.
// Latency: a FIFO pop shows up as tvalid one cycle later; done pulses one cycle after the tlast beat is accepted.
// Backpressure: when tready=0 the output beat holds and no pop occurs; a new beat loads while the current one is accepted, so there is no bubble.
module stream_tx_pkt #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 13
) (
  input  logic                  sclk,
  input  logic                  s_rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      pkt_len,
  input  logic [DATA_W/8-1:0]   last_keep,
  output logic                  fifo_rd_en,
  input  logic [DATA_W-1:0]     fifo_rd_data,
  input  logic                  fifo_empty,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err
);

  localparam int KEEP_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [KEEP_W-1:0]   keep_q, keep_d;
  logic [CNT_W-1:0]    issue_q, issue_d;
  logic [CNT_W-1:0]    sent_q, sent_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic [KEEP_W-1:0]   tkeep_q, tkeep_d;
  logic                tlast_q, tlast_d;
  logic                tvalid_q, tvalid_d;
  logic                len_err_q, len_err_d;
  logic                rd_en;
  logic                accept;

  // Next-state logic. The pop decision and the output register load are made together,
  // so an accepted beat is replaced in the same cycle whenever the FIFO can supply the next word.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    keep_d    = keep_q;
    issue_d   = issue_q;
    sent_d    = sent_q;
    tdata_d   = tdata_q;
    tkeep_d   = tkeep_q;
    tlast_d   = tlast_q;
    tvalid_d  = tvalid_q;
    len_err_d = 1'b0;
    rd_en     = 1'b0;
    accept    = tvalid_q & m_axis_tready;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (pkt_len != '0) begin
            len_d   = pkt_len;
            keep_d  = last_keep;
            issue_d = '0;
            sent_d  = '0;
            state_d = ST_SEND;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end

      ST_SEND: begin
        rd_en = ~fifo_empty & (issue_q < len_q) & (~tvalid_q | m_axis_tready);
        if (accept) begin
          // The slot empties unless a load below refills it in the same cycle.
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          sent_d   = sent_q + ONE;
          if (tlast_q) begin
            state_d = ST_DONE;
          end
        end
        if (rd_en) begin
          tdata_d  = fifo_rd_data;
          tvalid_d = 1'b1;
          issue_d  = issue_q + ONE;
          if (issue_q == len_q - ONE) begin
            tlast_d = 1'b1;
            tkeep_d = keep_q;
          end else begin
            tlast_d = 1'b0;
            tkeep_d = '1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset drops any packet in progress.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      keep_q    <= '0;
      issue_q   <= '0;
      sent_q    <= '0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      keep_q    <= keep_d;
      issue_q   <= issue_d;
      sent_q    <= sent_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tlast_q   <= tlast_d;
      tvalid_q  <= tvalid_d;
      len_err_q <= len_err_d;
    end
  end

  // The pop is gated by reset so the FIFO is never drained while the block is being cleared.
  assign fifo_rd_en    = rd_en & ~s_rst;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign len_err       = len_err_q;

endmodule
